// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles the fetch port, the data port and the unified memory
//             port that mem_arbiter connects.
//             slave  = arbiter view.
//             master = environment view (CPU requesters plus memory).
//  Revision : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // instruction-fetch requester (read-only)
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;

   // data requester (load/store)
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   // ack qualifier shared by both requesters
   logic              bus_err;

   // unified memory port
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport slave (
      input  i_req, i_addr,
      output i_ack, i_rdata,
      input  d_req, d_we, d_addr, d_wdata,
      output d_ack, d_rdata,
      output bus_err,
      output mem_addr, mem_wdata, mem_read, mem_write,
      input  mem_rdata, mem_ready
   );

   modport master (
      output i_req, i_addr,
      input  i_ack, i_rdata,
      output d_req, d_we, d_addr, d_wdata,
      input  d_ack, d_rdata,
      input  bus_err,
      input  mem_addr, mem_wdata, mem_read, mem_write,
      output mem_rdata, mem_ready
   );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one memory port between the instruction-fetch and data
//             requesters. One transaction at a time: IDLE -> BUSY_I|BUSY_D ->
//             DONE -> IDLE. Strobes are held through BUSY until mem_ready,
//             the ack is a one-cycle pulse in DONE, and a hung access is
//             aborted with bus_err after TIMEOUT busy cycles (0 = never).
//  Options  : ARB_RR_EN defined   -> round-robin between the two requesters.
//             ARB_RR_EN undefined -> fixed priority, data over instruction.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 64
) (
   input  wire logic       clk,
   input  wire logic       rst,   // asynchronous, active low
   mem_arbiter_if.slave    bus
);

   localparam int CNT_W = 16;
   // counter value seen in the last allowed busy cycle
   localparam logic [CNT_W-1:0] c_to_last = CNT_W'(TIMEOUT - 1);
   localparam bit               c_to_en   = (TIMEOUT != 0);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY_I = 2'd1,
      ST_BUSY_D = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [ADDR_W-1:0] r_mem_addr,  w_addr_nxt;
   logic [DATA_W-1:0] r_mem_wdata, w_wdata_nxt;
   logic              r_mem_read,  w_read_nxt;
   logic              r_mem_write, w_write_nxt;
   logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
   logic              r_i_ack,     w_i_ack_nxt;
   logic              r_d_ack,     w_d_ack_nxt;
   logic              r_bus_err,   w_err_nxt;
   logic [DATA_W-1:0] r_i_rdata,   w_i_rdata_nxt;
   logic [DATA_W-1:0] r_d_rdata,   w_d_rdata_nxt;

   logic              w_pick_d;
   logic              w_pick_i;
   logic              w_to_hit;

`ifdef ARB_RR_EN
   logic              r_last_d;   // 1 = last grant went to data, 0 = to fetch

   // On contention grant whichever requester was not served last
   always_comb begin
      w_pick_d = bus.d_req && (!bus.i_req || !r_last_d);
      w_pick_i = bus.i_req && !w_pick_d;
   end

   // Remember the winner of every grant taken in IDLE
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_d <= 1'b0;
      end else if (r_state == ST_IDLE && (w_pick_d || w_pick_i)) begin
         r_last_d <= w_pick_d;
      end
   end
`else
   // Fixed priority: data wins whenever it is requesting
   always_comb begin
      w_pick_d = bus.d_req;
      w_pick_i = bus.i_req && !bus.d_req;
   end
`endif

   // Abort when the busy cycle that just ran out of budget sees no mem_ready
   assign w_to_hit = c_to_en && (r_cnt == c_to_last);

   // Next-state and next-value logic for the FSM and its registered outputs
   always_comb begin
      w_state_nxt   = r_state;
      w_addr_nxt    = r_mem_addr;
      w_wdata_nxt   = r_mem_wdata;
      w_read_nxt    = r_mem_read;
      w_write_nxt   = r_mem_write;
      w_cnt_nxt     = r_cnt;
      w_i_ack_nxt   = 1'b0;
      w_d_ack_nxt   = 1'b0;
      w_err_nxt     = r_bus_err;
      w_i_rdata_nxt = r_i_rdata;
      w_d_rdata_nxt = r_d_rdata;

      case (r_state)
         ST_IDLE: begin
            w_err_nxt = 1'b0;
            if (w_pick_d) begin
               w_state_nxt = ST_BUSY_D;
               w_addr_nxt  = bus.d_addr;
               w_wdata_nxt = bus.d_wdata;
               w_read_nxt  = !bus.d_we;
               w_write_nxt = bus.d_we;
               w_cnt_nxt   = '0;
            end else if (w_pick_i) begin
               w_state_nxt = ST_BUSY_I;
               w_addr_nxt  = bus.i_addr;
               w_wdata_nxt = '0;          // fetches carry no write data
               w_read_nxt  = 1'b1;
               w_write_nxt = 1'b0;
               w_cnt_nxt   = '0;
            end
         end

         ST_BUSY_I, ST_BUSY_D: begin
            if (bus.mem_ready) begin
               w_state_nxt = ST_DONE;
               w_read_nxt  = 1'b0;
               w_write_nxt = 1'b0;
               if (r_state == ST_BUSY_I) begin
                  w_i_ack_nxt   = 1'b1;
                  w_i_rdata_nxt = bus.mem_rdata;
               end else begin
                  w_d_ack_nxt = 1'b1;
                  // a store keeps the previous load data
                  if (!r_mem_write) begin
                     w_d_rdata_nxt = bus.mem_rdata;
                  end
               end
            end else if (w_to_hit) begin
               w_state_nxt = ST_DONE;
               w_read_nxt  = 1'b0;
               w_write_nxt = 1'b0;
               w_err_nxt   = 1'b1;
               if (r_state == ST_BUSY_I) begin
                  w_i_ack_nxt   = 1'b1;
                  w_i_rdata_nxt = '0;
               end else begin
                  w_d_ack_nxt   = 1'b1;
                  w_d_rdata_nxt = '0;
               end
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end

         ST_DONE: begin
            // requests and mem_ready are ignored here; the ack lasts one cycle
            w_state_nxt = ST_IDLE;
            w_err_nxt   = 1'b0;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Output, read-data and timeout-counter registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_cnt       <= '0;
         r_i_ack     <= 1'b0;
         r_d_ack     <= 1'b0;
         r_bus_err   <= 1'b0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
      end else begin
         r_mem_addr  <= w_addr_nxt;
         r_mem_wdata <= w_wdata_nxt;
         r_mem_read  <= w_read_nxt;
         r_mem_write <= w_write_nxt;
         r_cnt       <= w_cnt_nxt;
         r_i_ack     <= w_i_ack_nxt;
         r_d_ack     <= w_d_ack_nxt;
         r_bus_err   <= w_err_nxt;
         r_i_rdata   <= w_i_rdata_nxt;
         r_d_rdata   <= w_d_rdata_nxt;
      end
   end

   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_read  = r_mem_read;
   assign bus.mem_write = r_mem_write;
   assign bus.i_ack     = r_i_ack;
   assign bus.d_ack     = r_d_ack;
   assign bus.bus_err   = r_bus_err;
   assign bus.i_rdata   = r_i_rdata;
   assign bus.d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. A transaction-level model
//             predicts every registered output each cycle; directed tests
//             add hand-computed expectations.
//  Options  : ARB_RR_EN selects the round-robin expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TO     = 8;
`ifdef ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // ---------------- transaction-level model ----------------
   int          m_owner;   // 0 none, 1 fetch, 2 data
   bit          m_we;
   bit          m_done;
   bit          m_last_d;
   int          m_busy;    // busy cycles spent on the current access
   bit          take_d;
   logic [31:0] e_addr, e_wdata, e_irdata, e_drdata;
   bit          e_rd, e_wr, e_iack, e_dack, e_err;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_owner = 0; m_we = 0; m_done = 0; m_last_d = 0; m_busy = 0;
         e_addr = 0; e_wdata = 0; e_irdata = 0; e_drdata = 0;
         e_rd = 0; e_wr = 0; e_iack = 0; e_dack = 0; e_err = 0;
      end else if (m_done) begin
         m_done = 0; e_iack = 0; e_dack = 0; e_err = 0;
      end else if (m_owner != 0) begin
         m_busy++;
         if (bus.mem_ready || (TO != 0 && m_busy == TO)) begin
            e_err = !bus.mem_ready;
            if (m_owner == 1) begin
               e_irdata = bus.mem_ready ? bus.mem_rdata : 32'h0;
               e_iack   = 1;
            end else begin
               if (!bus.mem_ready) e_drdata = 32'h0;
               else if (!m_we)     e_drdata = bus.mem_rdata;
               e_dack = 1;
            end
            e_rd = 0; e_wr = 0; m_owner = 0; m_done = 1;
         end
      end else if (bus.d_req || bus.i_req) begin
         take_d   = bus.d_req && (!bus.i_req || !RR || !m_last_d);
         m_last_d = take_d;
         m_busy   = 0;
         if (take_d) begin
            m_owner = 2; m_we = bus.d_we;
            e_addr  = bus.d_addr; e_wdata = bus.d_wdata;
            e_rd    = !bus.d_we;  e_wr    = bus.d_we;
         end else begin
            m_owner = 1; m_we = 0;
            e_addr  = bus.i_addr;
            e_rd    = 1; e_wr = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst) begin
         check("mem_read",  bus.mem_read,  e_rd);
         check("mem_write", bus.mem_write, e_wr);
         check("mem_addr",  bus.mem_addr,  e_addr);
         check("i_ack",     bus.i_ack,     e_iack);
         check("d_ack",     bus.d_ack,     e_dack);
         check("bus_err",   bus.bus_err,   e_err);
         check("i_rdata",   bus.i_rdata,   e_irdata);
         check("d_rdata",   bus.d_rdata,   e_drdata);
         if (e_wr) check("mem_wdata", bus.mem_wdata, e_wdata);
      end
   end

   // ---------------- directed stimulus ----------------
   int   rd_hi, wr_hi, lat, addr_chg, nacks, extra;
   bit   err, got;
   logic [3:0] seq;

   // One transaction; the memory answers after wait_n busy cycles.
   // toggle: flip i_req/i_addr while busy and pulse mem_ready in DONE.
   task automatic run_txn(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int wait_n, input bit toggle,
                          output int o_rd, output int o_wr, output int o_lat,
                          output bit o_err, output bit o_got, output int o_chg);
      logic [31:0] a0;
      int busy;
      o_rd = 0; o_wr = 0; o_lat = 0; o_err = 0; o_got = 0; o_chg = 0;
      busy = 0; a0 = 0;
      @(negedge clk);
      if (is_d) begin
         bus.d_req = 1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
      end else begin
         bus.i_req = 1; bus.i_addr = addr;
      end
      bus.mem_rdata = rdata;
      bus.mem_ready = 0;
      for (int k = 1; k <= 60 && !o_got; k++) begin
         @(negedge clk);
         if (bus.mem_read)  o_rd++;
         if (bus.mem_write) o_wr++;
         if (bus.mem_read || bus.mem_write) begin
            busy++;
            if (busy == 1) a0 = bus.mem_addr;
            else if (bus.mem_addr != a0) o_chg++;
            bus.mem_ready = (busy > wait_n);
            if (toggle) begin
               bus.i_req  = ~bus.i_req;
               bus.i_addr = bus.i_addr + 32'd4;
            end
         end else begin
            bus.mem_ready = toggle;
         end
         if (bus.i_ack || bus.d_ack) begin
            o_got = 1; o_lat = k; o_err = bus.bus_err;
            bus.i_req = 0; bus.d_req = 0;
            bus.mem_ready = toggle;
         end
      end
      check("txn_completed", o_got, 1'b1);
      @(negedge clk);
      bus.mem_ready = 0;
   endtask

   initial begin
      bus.i_req = 0; bus.i_addr = 0;
      bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
      bus.mem_rdata = 0; bus.mem_ready = 0;

      // reset state
      #1;
      check("reset_mem_read", bus.mem_read, 1'b0);
      check("reset_i_ack",    bus.i_ack,    1'b0);
      check("reset_mem_addr", bus.mem_addr, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1;

      // 1: fetch, memory ready on the first busy cycle
      run_txn(0, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, rd_hi, wr_hi, lat, err, got, addr_chg);
      check("t1_read_cycles",  rd_hi, 1);
      check("t1_write_cycles", wr_hi, 0);
      check("t1_ack_latency",  lat, 2);
      check("t1_bus_err",      err, 1'b0);
      check("t1_i_rdata",      bus.i_rdata, 32'hDEADBEEF);

      // 3: both requesters held for four transactions
      @(negedge clk);
      bus.i_req = 1; bus.i_addr = 32'h40;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
      bus.mem_rdata = 32'h0BADF00D; bus.mem_ready = 1;
      seq = 0; nacks = 0;
      for (int k = 0; k < 60 && nacks < 4; k++) begin
         @(negedge clk);
         if (bus.d_ack)      begin seq = {seq[2:0], 1'b1}; nacks++; end
         else if (bus.i_ack) begin seq = {seq[2:0], 1'b0}; nacks++; end
      end
      bus.i_req = 0; bus.d_req = 0; bus.mem_ready = 0;
      check("t3_ack_count", nacks, 4);
      check("t3_grant_order", seq, RR ? 4'b1010 : 4'b1111);

      // load, then 2: store with three wait cycles must not touch d_rdata
      run_txn(1, 0, 32'h24, 32'h0, 32'hCAFE0001, 1, 0, rd_hi, wr_hi, lat, err, got, addr_chg);
      check("load_read_cycles", rd_hi, 2);
      check("load_d_rdata",     bus.d_rdata, 32'hCAFE0001);
      run_txn(1, 1, 32'h20, 32'h1234, 32'h99999999, 3, 0, rd_hi, wr_hi, lat, err, got, addr_chg);
      check("t2_write_cycles", wr_hi, 4);
      check("t2_read_cycles",  rd_hi, 0);
      check("t2_addr_stable",  addr_chg, 0);
      check("t2_d_rdata_kept", bus.d_rdata, 32'hCAFE0001);

      // 4: load with no mem_ready times out after TO busy cycles
      run_txn(1, 0, 32'h30, 32'h0, 32'h77777777, 1000, 0, rd_hi, wr_hi, lat, err, got, addr_chg);
      check("t4_read_cycles", rd_hi, TO);
      check("t4_bus_err",     err, 1'b1);
      check("t4_d_rdata",     bus.d_rdata, 32'h0);
      check("t4_err_cleared", bus.bus_err, 1'b0);

      // 5: asynchronous reset in the middle of a fetch
      @(negedge clk);
      bus.i_req = 1; bus.i_addr = 32'h100; bus.mem_ready = 0;
      repeat (3) @(negedge clk);
      check("t5_busy_before_rst", bus.mem_read, 1'b1);
      @(posedge clk);
      #2 rst = 0;
      #1;
      check("t5_rst_mem_read", bus.mem_read, 1'b0);
      check("t5_rst_mem_addr", bus.mem_addr, 32'h0);
      check("t5_rst_i_rdata",  bus.i_rdata,  32'h0);
      check("t5_rst_i_ack",    bus.i_ack,    1'b0);
      @(negedge clk);
      rst = 1;
      run_txn(0, 0, 32'h100, 32'h0, 32'h5555AAAA, 0, 0, rd_hi, wr_hi, lat, err, got, addr_chg);
      check("t5_restart_rdata", bus.i_rdata, 32'h5555AAAA);
      check("t5_restart_err",   err, 1'b0);

      // 6: mem_ready in IDLE, request toggling while busy, mem_ready in DONE
      @(negedge clk);
      bus.mem_ready = 1;
      extra = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.i_ack || bus.d_ack) extra++;
      end
      bus.mem_ready = 0;
      check("t6_idle_ready_no_ack", extra, 0);
      run_txn(0, 0, 32'h200, 32'h0, 32'h13579BDF, 2, 1, rd_hi, wr_hi, lat, err, got, addr_chg);
      check("t6_addr_stable", addr_chg, 0);
      check("t6_read_cycles", rd_hi, 3);
      check("t6_i_rdata",     bus.i_rdata, 32'h13579BDF);
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.i_ack || bus.d_ack) extra++;
      end
      check("t6_no_extra_ack", extra, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // hard stop if the run never reaches its summary
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
